// File: rtl/dwrr_pkg.sv
// Shared constants and types for the DWRR queue bank (default sizes and derived widths).
package dwrr_pkg;

    localparam int NUM_REQS_DEF = 4;
    localparam int DEPTH_DEF    = 8;
    localparam int DWID_DEF     = 32;

    localparam int IDWID_DEF  = $clog2(NUM_REQS_DEF);
    localparam int PTRWID_DEF = $clog2(DEPTH_DEF);
    localparam int CNTWID_DEF = $clog2(DEPTH_DEF + 1);

    typedef logic [IDWID_DEF-1:0] flow_id_t;

endpackage

// File: rtl/dwrr_queues_pkt_fifo.sv
// Single-queue packet FIFO; head word is presented combinationally on rd_data.
module pkt_fifo #(
    parameter int DEPTH  = 8,
    parameter int DWID   = 32,
    parameter int PTRWID = $clog2(DEPTH),
    parameter int CNTWID = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWID-1:0]   wr_data,
    input  logic              rd_en,
    output logic [DWID-1:0]   rd_data,
    output logic [CNTWID-1:0] count,
    output logic              full,
    output logic              empty
);

    logic [DWID-1:0]   mem_q [DEPTH];
    logic [PTRWID-1:0] wptr_q, wptr_d;
    logic [PTRWID-1:0] rptr_q, rptr_d;
    logic [CNTWID-1:0] count_q, count_d;
    logic              do_wr, do_rd;

    assign full    = (count_q == CNTWID'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rptr_q];

    // Fullness/emptiness come from current state: a same-cycle pop never frees space,
    // and a same-cycle push never satisfies a pop.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr) begin
            wptr_d = wptr_q + PTRWID'(1);
        end
        if (do_rd) begin
            rptr_d = rptr_q + PTRWID'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNTWID'(1);
            2'b01:   count_d = count_q - CNTWID'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/dwrr_queues.sv
// Per-requestor packet queue bank feeding the DWRR arbiter.
// Optional QUEUE_OCC_EN exposes the packed per-queue occupancy on port occ.
module dwrr_queues
    import dwrr_pkg::*;
#(
    parameter int NUM_REQS = NUM_REQS_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DWID     = DWID_DEF,
    parameter int IDWID    = $clog2(NUM_REQS),
    parameter int PTRWID   = $clog2(DEPTH),
    parameter int CNTWID   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IDWID-1:0]           in_id,
    input  logic [DWID-1:0]            in_data,
    output logic                       in_ready,
    input  logic [NUM_REQS-1:0]        gnt,
    output logic [NUM_REQS-1:0]        reqs,
    output logic                       out_valid,
    output logic [IDWID-1:0]           out_id,
    output logic [DWID-1:0]            out_data,
`ifdef QUEUE_OCC_EN
    output logic [NUM_REQS*CNTWID-1:0] occ,
`endif
    output logic                       err
);

    logic [NUM_REQS-1:0] full, empty, wr_en, rd_en, gnt_sel;
    logic [DWID-1:0]     rd_data [NUM_REQS];
    logic [CNTWID-1:0]   cnt     [NUM_REQS];
    logic                id_ok;
    logic                multi_gnt, empty_gnt;

    logic                out_valid_q, out_valid_d;
    logic [IDWID-1:0]    out_id_q, out_id_d;
    logic [DWID-1:0]     out_data_q, out_data_d;
    logic                err_q, err_d;

    generate
        if ((2 ** IDWID) > NUM_REQS) begin : g_id_chk
            assign id_ok = (in_id < IDWID'(NUM_REQS));
        end else begin : g_id_all
            assign id_ok = 1'b1;
        end
    endgenerate

    assign in_ready = id_ok & (cnt[in_id] != CNTWID'(DEPTH));

    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            wr_en[i] = in_valid & id_ok & ~full[i] & (in_id == IDWID'(i));
        end
    end

    // Isolate the lowest set grant bit so a malformed grant still pops one queue.
    assign gnt_sel   = gnt & (~gnt + NUM_REQS'(1));
    assign rd_en     = gnt_sel & ~empty;
    assign multi_gnt = |(gnt & (gnt - NUM_REQS'(1)));
    assign empty_gnt = |(gnt_sel & empty);

    generate
        for (genvar g = 0; g < NUM_REQS; g++) begin : g_q
            pkt_fifo #(
                .DEPTH  (DEPTH),
                .DWID   (DWID),
                .PTRWID (PTRWID),
                .CNTWID (CNTWID)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (wr_en[g]),
                .wr_data (in_data),
                .rd_en   (rd_en[g]),
                .rd_data (rd_data[g]),
                .count   (cnt[g]),
                .full    (full[g]),
                .empty   (empty[g])
            );
`ifdef QUEUE_OCC_EN
            assign occ[g*CNTWID +: CNTWID] = cnt[g];
`endif
        end
    endgenerate

    assign reqs = ~empty;

    always_comb begin
        out_valid_d = |rd_en;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (rd_en[i]) begin
                out_id_d   = IDWID'(i);
                out_data_d = rd_data[i];
            end
        end
        err_d = err_q | empty_gnt | multi_gnt | (in_valid & ~id_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dwrr_queues.sv
// Self-checking bench for dwrr_queues: directed scenarios plus randomized traffic vs a queue model.
module tb_dwrr_queues;
    import dwrr_pkg::*;

    localparam int NR = 4;
    localparam int DP = 8;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    flow_id_t       in_id;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  reqs;
    logic           out_valid;
    flow_id_t       out_id;
    logic [DW-1:0]  out_data;
    logic           err;

    always #5 clk = ~clk;

    dwrr_queues #(
        .NUM_REQS (NR),
        .DEPTH    (DP),
        .DWID     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_id     (in_id),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .gnt       (gnt),
        .reqs      (reqs),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
        .err       (err)
    );

    // Reference model: one queue per flow plus the registered output fields.
    logic [DW-1:0] mq [NR][$];
    logic          m_ov;
    flow_id_t      m_id;
    logic [DW-1:0] m_data;
    logic          m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] m_reqs();
        logic [NR-1:0] r;
        for (int i = 0; i < NR; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    task automatic model_step(input logic v, input flow_id_t id, input logic [DW-1:0] d,
                              input logic [NR-1:0] g, input logic r);
        int  sel;
        int  ones;
        logic acc;
        if (!r) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
            m_ov = 0; m_id = '0; m_data = '0; m_err = 0;
            return;
        end
        acc  = v && (mq[id].size() < DP);
        sel  = -1;
        ones = 0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (g[i]) begin
                sel = i;
                ones++;
            end
        end
        if (ones > 1) m_err = 1;
        m_ov = 0;
        if (sel >= 0) begin
            if (mq[sel].size() == 0) begin
                m_err = 1;
            end else begin
                m_ov   = 1;
                m_id   = flow_id_t'(sel);
                m_data = mq[sel].pop_front();
            end
        end
        if (acc) mq[id].push_back(d);
    endtask

    // One clock cycle: drive, check in_ready, advance model, compare registered outputs.
    task automatic cyc(input logic v, input flow_id_t id, input logic [DW-1:0] d,
                       input logic [NR-1:0] g, input logic r);
        in_valid = v; in_id = id; in_data = d; gnt = g; rst = r;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, (mq[id].size() < DP)});
        @(posedge clk);
        model_step(v, id, d, g, r);
        @(negedge clk);
        chk("reqs",      {60'd0, reqs},      {60'd0, m_reqs()});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        chk("out_id",    {62'd0, out_id},    {62'd0, m_id});
        chk("out_data",  {32'd0, out_data},  {32'd0, m_data});
        chk("err",       {63'd0, err},       {63'd0, m_err});
    endtask

    initial begin
        rst = 0; in_valid = 0; in_id = '0; in_data = '0; gnt = '0;
        m_ov = 0; m_id = '0; m_data = '0; m_err = 0;
        @(negedge clk);
        cyc(0, 0, 0, 4'b0000, 0);
        cyc(0, 0, 0, 4'b0000, 0);
        chk("rst_reqs", {60'd0, reqs}, 64'd0);
        chk("rst_err",  {63'd0, err},  64'd0);
        chk("rst_ov",   {63'd0, out_valid}, 64'd0);

        // Single enqueue/pop
        cyc(1, 2, 32'hA5, 4'b0000, 1);
        chk("t1_reqs", {60'd0, reqs}, 64'b0100);
        cyc(0, 0, 0, 4'b0100, 1);
        chk("t1_ov",   {63'd0, out_valid}, 64'd1);
        chk("t1_id",   {62'd0, out_id}, 64'd2);
        chk("t1_data", {32'd0, out_data}, 64'hA5);
        chk("t1_reqs0", {60'd0, reqs}, 64'd0);

        // Fill queue 1, full-queue behaviour
        for (int k = 0; k < 8; k++) cyc(1, 1, k, 4'b0000, 1);
        in_valid = 0; in_id = 1; gnt = '0; #1;
        chk("t2_rdy1", {63'd0, in_ready}, 64'd0);
        in_id = 0; #1;
        chk("t2_rdy0", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        cyc(1, 1, 32'h99, 4'b0010, 1);
        chk("t2_pop0", {32'd0, out_data}, 64'd0);
        chk("t2_cnt7", 64'(mq[1].size()), 64'd7);
        for (int k = 0; k < 7; k++) cyc(0, 0, 0, 4'b0010, 1);
        chk("t2_last", {32'd0, out_data}, 64'd7);
        chk("t2_empty", {60'd0, reqs}, 64'd0);

        // Simultaneous enqueue and pop on a one-entry queue
        cyc(1, 3, 32'h33, 4'b0000, 1);
        cyc(1, 3, 32'h11, 4'b1000, 1);
        chk("t3_old", {32'd0, out_data}, 64'h33);
        chk("t3_req", {60'd0, reqs}, 64'b1000);
        cyc(0, 0, 0, 4'b1000, 1);
        chk("t3_new", {32'd0, out_data}, 64'h11);

        // Pointer wrap-around on queue 0
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, k, 4'b0000, 1);
            cyc(0, 0, 0, 4'b0001, 1);
            chk("t4_data", {32'd0, out_data}, 64'(k));
        end
        chk("t4_err", {63'd0, err}, 64'd0);

        // Protocol errors
        cyc(0, 0, 0, 4'b0010, 1);
        chk("t5_err",  {63'd0, err}, 64'd1);
        chk("t5_ov",   {63'd0, out_valid}, 64'd0);
        cyc(1, 0, 32'hAA, 4'b0000, 1);
        cyc(1, 1, 32'hBB, 4'b0000, 1);
        cyc(0, 0, 0, 4'b0011, 1);
        chk("t5_mid",  {62'd0, out_id}, 64'd0);
        chk("t5_mdat", {32'd0, out_data}, 64'hAA);
        chk("t5_mreq", {60'd0, reqs}, 64'b0010);
        cyc(0, 0, 0, 4'b0000, 1);
        chk("t5_stky", {63'd0, err}, 64'd1);
        cyc(0, 0, 0, 4'b0000, 0);
        chk("t5_clr",  {63'd0, err}, 64'd0);

        // Reset mid-stream
        cyc(1, 0, 1, 4'b0000, 1);
        cyc(1, 1, 2, 4'b0000, 1);
        cyc(1, 2, 3, 4'b0000, 1);
        cyc(1, 2, 4, 4'b0000, 1);
        cyc(1, 0, 5, 4'b0100, 0);
        chk("t6_reqs", {60'd0, reqs}, 64'd0);
        chk("t6_ov",   {63'd0, out_valid}, 64'd0);
        cyc(1, 2, 32'h77, 4'b0000, 1);
        chk("t6_req2", {60'd0, reqs}, 64'b0100);
        cyc(0, 0, 0, 4'b0100, 1);
        chk("t6_data", {32'd0, out_data}, 64'h77);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NR-1:0] g;
            int            r;
            r = $urandom_range(0, 9);
            if (r < 5)      g = NR'(1) << $urandom_range(0, NR - 1);
            else if (r < 8) g = '0;
            else            g = NR'($urandom);
            cyc(($urandom_range(0, 2) != 0), flow_id_t'($urandom_range(0, NR - 1)),
                $urandom, g, ($urandom_range(0, 299) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
